// File: rtl/led_panel_pkg.sv
// Shared definitions for the HUB75 panel controllers.
//   - scan_state_t : scan FSM state encoding
//   - clog2/idx_w  : constant width helpers for parameter-derived ports
//   - OE_ACTIVE    : panel output-enable level that lights the LEDs (active low)
//   - LATCH_ACTIVE : panel latch strobe level (active high)
package led_panel_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        WAIT  = 3'd2,
        BLANK = 3'd3,
        LATCH = 3'd4
    } scan_state_t;

    localparam logic OE_ACTIVE    = 1'b0;
    localparam logic LATCH_ACTIVE = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits for a count of one.
    function automatic int idx_w(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/led_oe_timer.sv
// Display window timer for one BCM plane.
// A load captures the window length; the counter then runs down to zero.
// led_oe is registered and aligned with the counter: it is driven active
// for the first part of the window and inactive (blank) otherwise.
// Optional feature macro: LED_SCAN_BRIGHTNESS_EN adds a global dim input that
// shortens the lit part of the window without changing its length.
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   load         capture window into the counter at this edge
//   window       window length in clk cycles
//   brightness   global dim, lit = (window*(brightness+1))>>8 (macro only)
//   led_oe       panel output enable, active low
//   expired      counter reaches zero at this edge (count is 0 or 1)
module led_oe_timer
    import led_panel_pkg::*;
#(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] window,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    output logic          led_oe,
    output logic          expired
);

    logic [TW-1:0] count_q, count_d;
    logic          led_oe_q, led_oe_d;

`ifdef LED_SCAN_BRIGHTNESS_EN
    // Lit while the count is above thresh: the first (window - thresh) clocks.
    logic [TW-1:0] thresh_q, thresh_d;
    logic [TW+8:0] on_prod;
    logic [TW-1:0] on_len;

    always_comb begin
        on_prod = {9'd0, window} * {{TW{1'b0}}, ({1'b0, brightness} + 9'd1)};
        on_len  = on_prod[TW+7:8];
    end
`endif

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = window;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
`ifdef LED_SCAN_BRIGHTNESS_EN
        thresh_d = load ? (window - on_len) : thresh_q;
        led_oe_d = (count_d > thresh_d) ? OE_ACTIVE : ~OE_ACTIVE;
`else
        led_oe_d = (count_d != '0) ? OE_ACTIVE : ~OE_ACTIVE;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            led_oe_q <= ~OE_ACTIVE;
`ifdef LED_SCAN_BRIGHTNESS_EN
            thresh_q <= '0;
`endif
        end else begin
            count_q  <= count_d;
            led_oe_q <= led_oe_d;
`ifdef LED_SCAN_BRIGHTNESS_EN
            thresh_q <= thresh_d;
`endif
        end
    end

    assign led_oe  = led_oe_q;
    assign expired = (count_q <= TW'(1));

endmodule

// File: rtl/led_scan_ctrl.sv
// HUB75 scan controller with binary-code-modulated colour depth.
// Shifts one bit plane of a row into the panel while the previously latched
// plane is displayed, then blanks, latches and starts the next plane.
// Scan order: planes 0..PLANES-1 of a row, then the next row, wrapping.
// Optional feature macro: LED_SCAN_BRIGHTNESS_EN adds the brightness input.
//
// state | meaning
// IDLE  | not scanning, panel blanked
// SHIFT | clocking COLS columns of the next plane into the panel
// WAIT  | shift done, current display window still running
// BLANK | one blank clock before the latch
// LATCH | one-clock latch strobe, dmux/plane update, window load
//
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   enable       run scanning; dropping it stops after the current window
//   brightness   global dim (macro only)
//   x            framebuffer column being shifted
//   fb_row       framebuffer row being shifted
//   fb_plane     bit plane being shifted
//   led_clk      panel shift clock, panel samples on its rising edge
//   led_latch    panel latch strobe, active high
//   led_oe       panel output enable, active low
//   dmux         row currently displayed
//   frame_start  pulse with the latch of row 0 plane 0
module led_scan_ctrl
    import led_panel_pkg::*;
#(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 4,
    parameter int PLANES   = 4,
    parameter int CLK_DIV  = 2,
    parameter int BASE_OE  = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [7:0]                  brightness,
`endif
    output logic [idx_w(COLS)-1:0]      x,
    output logic [ROW_BITS-1:0]         fb_row,
    output logic [idx_w(PLANES)-1:0]    fb_plane,
    output logic                        led_clk,
    output logic                        led_latch,
    output logic                        led_oe,
    output logic [ROW_BITS-1:0]         dmux,
    output logic                        frame_start
);

    localparam int X_W  = idx_w(COLS);
    localparam int PL_W = idx_w(PLANES);
    localparam int DW   = idx_w(CLK_DIV);
    localparam int TW   = clog2(BASE_OE << (PLANES - 1)) + 1;

    localparam logic [X_W-1:0]  X_LAST   = X_W'(COLS - 1);
    localparam logic [PL_W-1:0] PL_LAST  = PL_W'(PLANES - 1);
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

    scan_state_t         state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [DW-1:0]       div_q, div_d;
    logic                led_clk_q, led_clk_d;
    logic [ROW_BITS-1:0] fb_row_q, fb_row_d;
    logic [PL_W-1:0]     fb_plane_q, fb_plane_d;
    logic [ROW_BITS-1:0] dmux_q, dmux_d;
    logic                led_latch_q, led_latch_d;
    logic                frame_start_q, frame_start_d;

    logic                timer_load;
    logic                timer_expired;
    logic [TW-1:0]       window;

    // Window of the plane being latched; fb_plane still points at it in LATCH.
    assign window = TW'(BASE_OE) << fb_plane_q;

    always_comb begin
        state_d    = state_q;
        x_d        = '0;
        div_d      = '0;
        led_clk_d  = 1'b0;
        fb_row_d   = fb_row_q;
        fb_plane_d = fb_plane_q;
        dmux_d     = dmux_q;
        timer_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = SHIFT;
            end
            SHIFT: begin
                x_d       = x_q;
                led_clk_d = led_clk_q;
                div_d     = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    led_clk_d = ~led_clk_q;
                    // Column advances on the falling edge of led_clk.
                    if (led_clk_q) begin
                        if (x_q == X_LAST) begin
                            x_d     = '0;
                            // Skip WAIT entirely when the window ends now.
                            state_d = timer_expired ? BLANK : WAIT;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                if (timer_expired) state_d = BLANK;
            end
            BLANK: begin
                state_d = enable ? LATCH : IDLE;
            end
            LATCH: begin
                state_d    = SHIFT;
                timer_load = 1'b1;
                if (fb_plane_q == PL_LAST) begin
                    fb_plane_d = '0;
                    fb_row_d   = fb_row_q + 1'b1;
                end else begin
                    fb_plane_d = fb_plane_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobe outputs are registered from the next state so they line up
        // with the LATCH cycle itself.
        led_latch_d   = (state_d == LATCH) ? LATCH_ACTIVE : ~LATCH_ACTIVE;
        frame_start_d = (state_d == LATCH) && (fb_row_q == '0) && (fb_plane_q == '0);
        if (state_d == LATCH) dmux_d = fb_row_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            x_q           <= '0;
            div_q         <= '0;
            led_clk_q     <= 1'b0;
            fb_row_q      <= '0;
            fb_plane_q    <= '0;
            dmux_q        <= '0;
            led_latch_q   <= ~LATCH_ACTIVE;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            div_q         <= div_d;
            led_clk_q     <= led_clk_d;
            fb_row_q      <= fb_row_d;
            fb_plane_q    <= fb_plane_d;
            dmux_q        <= dmux_d;
            led_latch_q   <= led_latch_d;
            frame_start_q <= frame_start_d;
        end
    end

    led_oe_timer #(
        .TW(TW)
    ) u_oe_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .window     (window),
`ifdef LED_SCAN_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .led_oe     (led_oe),
        .expired    (timer_expired)
    );

    assign x           = x_q;
    assign fb_row      = fb_row_q;
    assign fb_plane    = fb_plane_q;
    assign led_clk     = led_clk_q;
    assign led_latch   = led_latch_q;
    assign dmux        = dmux_q;
    assign frame_start = frame_start_q;

endmodule
